// File: rtl/txenc_fm0_miller_if.sv
// Frame generator <-> line encoder bundle for txenc_fm0_miller.
// The frame generator is the master; the encoder is the slave.
interface txenc_fm0_miller_if;
    logic       st_enc;
    logic       en_fm0;
    logic [1:0] m;
    logic       trext;
    logic       send_data;
    logic       fg_complete;
    logic       clk_frm;
    logic       rpy_out;
    logic       enc_done;

    modport master (
        output st_enc, en_fm0, m, trext, send_data, fg_complete,
        input  clk_frm, rpy_out, enc_done
    );

    modport slave (
        input  st_enc, en_fm0, m, trext, send_data, fg_complete,
        output clk_frm, rpy_out, enc_done
    );
endinterface

// File: rtl/txenc_fm0_miller.sv
// FM0 / Miller (M=2,4,8) backscatter line encoder with bit clock and dummy-1 end-of-signaling.
// Optional macro FM0_VIOLATION_EN: suppress the FM0 boundary inversion on the preamble violation bit.
module txenc_fm0_miller #(
    parameter int CNTW = 5,
    parameter int BITW = 5
) (
    input  logic                clk_blf,
    input  logic                rst_for_new_package,
    txenc_fm0_miller_if.slave   bus
);

    typedef enum logic [1:0] {IDLE, ENC, DONE} state_t;

    state_t            state_q, state_d;
    logic [CNTW-1:0]   tcnt_q, tcnt_d;
    logic [BITW-1:0]   bcnt_q, bcnt_d;
    logic              lvl_q, lvl_d;
    logic              pb_q, pb_d;
    logic              bit_q, bit_d;
    logic              last_q, last_d;
    logic              clk_frm_q, clk_frm_d;
    logic              rpy_q, rpy_d;
    logic              done_q, done_d;

    logic [CNTW-1:0]   last_tick;
    logic [CNTW-1:0]   half_tick;
    logic              boundary;
    logic              viol_bit;
    logic              encode;
    logic              active;
    logic              cur_bit;

    // Ticks per bit: 2 for FM0, 2M for Miller.
    always_comb begin
        last_tick = CNTW'(3);
        half_tick = CNTW'(2);
        if (bus.en_fm0) begin
            last_tick = CNTW'(1);
            half_tick = CNTW'(1);
        end else begin
            case (bus.m)
                2'b10: begin
                    last_tick = CNTW'(7);
                    half_tick = CNTW'(4);
                end
                2'b11: begin
                    last_tick = CNTW'(15);
                    half_tick = CNTW'(8);
                end
                default: begin
                    last_tick = CNTW'(3);
                    half_tick = CNTW'(2);
                end
            endcase
        end
    end

    assign boundary = (tcnt_q == '0);

`ifdef FM0_VIOLATION_EN
    assign viol_bit = (bcnt_q == (bus.trext ? BITW'(16) : BITW'(4)));
`else
    logic unused_trext;
    assign unused_trext = bus.trext;
    assign viol_bit     = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        tcnt_d    = tcnt_q;
        bcnt_d    = bcnt_q;
        lvl_d     = lvl_q;
        pb_d      = pb_q;
        bit_d     = bit_q;
        last_d    = last_q;
        encode    = 1'b0;
        cur_bit   = bit_q;

        unique case (state_q)
            IDLE: begin
                if (boundary && bus.st_enc) begin
                    state_d = ENC;
                    encode  = 1'b1;
                end
            end
            ENC: begin
                if (boundary) begin
                    if (last_q) begin
                        state_d = DONE;
                    end else begin
                        encode = 1'b1;
                    end
                end
            end
            DONE: begin
            end
            default: state_d = IDLE;
        endcase

        // A new bit is latched at every boundary that starts an encoded bit period.
        if (encode) begin
            cur_bit = bus.send_data;
            bit_d   = bus.send_data;
            last_d  = bus.fg_complete;
            if (bcnt_q != '1) begin
                bcnt_d = bcnt_q + BITW'(1);
            end
        end

        active = (state_d == ENC);

        if (active) begin
            if (boundary) begin
                if (bus.en_fm0) begin
                    if (!viol_bit) begin
                        lvl_d = ~lvl_q;
                    end
                end else begin
                    if (!cur_bit && !pb_q) begin
                        lvl_d = ~lvl_q;
                    end
                    pb_d = cur_bit;
                end
            end else if (tcnt_q == half_tick) begin
                if (bus.en_fm0 ? !cur_bit : cur_bit) begin
                    lvl_d = ~lvl_q;
                end
            end
        end

        if (state_d != DONE) begin
            tcnt_d = (tcnt_q >= last_tick) ? '0 : tcnt_q + CNTW'(1);
        end

        // Miller subcarrier is high on even ticks.
        clk_frm_d = (state_d != DONE) && (tcnt_q >= half_tick);
        rpy_d     = active && (bus.en_fm0 ? lvl_d : (lvl_d ^ ~tcnt_q[0]));
        done_d    = done_q || (state_d == DONE);
    end

    always_ff @(posedge clk_blf or posedge rst_for_new_package) begin
        if (rst_for_new_package) begin
            state_q   <= IDLE;
            tcnt_q    <= '0;
            bcnt_q    <= '0;
            lvl_q     <= 1'b0;
            pb_q      <= 1'b1;
            bit_q     <= 1'b0;
            last_q    <= 1'b0;
            clk_frm_q <= 1'b0;
            rpy_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tcnt_q    <= tcnt_d;
            bcnt_q    <= bcnt_d;
            lvl_q     <= lvl_d;
            pb_q      <= pb_d;
            bit_q     <= bit_d;
            last_q    <= last_d;
            clk_frm_q <= clk_frm_d;
            rpy_q     <= rpy_d;
            done_q    <= done_d;
        end
    end

    assign bus.clk_frm  = clk_frm_q;
    assign bus.rpy_out  = rpy_q;
    assign bus.enc_done = done_q;

endmodule
